alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer that shares one instance of the team's combinational 16-function ALU between two independent requesters. Each requester submits operands A, B and a 4-bit CMD over a valid/ready handshake. The block arbitrates round-robin, drives the shared ALU for a fixed number of settle cycles, and registers the result. It then returns the result to the winning requester over a second valid/ready handshake. It sits between the instruction-issue logic and the ALU, which is instantiated outside this block.

## Interface
- N, 32, operand/result width; must match the ALU instance.
- LAT, 1, ALU settle cycles before capture; legal range 1..15.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_0 / req_valid_1  in  1  requester has an operation pending.
- req_ready_0 / req_ready_1  out  1  operation accepted this cycle.
- req_a_0 / req_a_1  in  N  operand A.
- req_b_0 / req_b_1  in  N  operand B.
- req_cmd_0 / req_cmd_1  in  4  ALU function select.
- rsp_valid_0 / rsp_valid_1  out  1  result available for this requester.
- rsp_ready_0 / rsp_ready_1  in  1  requester consumes the result.
- rsp_z_0 / rsp_z_1  out  N  result.
- alu_a, alu_b  out  N  shared-ALU operands.
- alu_cmd  out  4  shared-ALU function select.
- alu_z  in  N  shared-ALU result (combinational from alu_a/alu_b/alu_cmd).
- busy  out  1  high in EXEC or RESP.
- grant_id  out  1  requester owning the current operation.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid is high, select a winner and assert that requester's req_ready for that cycle only.
  - req_ready is combinational: (state==IDLE) & req_valid_i & (winner==i). It is never high outside IDLE.
  - At the handshake, latch req_a/req_b/req_cmd into op registers and latch the winner into grant_id. Load the settle counter with LAT-1. Go to EXEC.
- **Arbitration**
  - Only one requester valid: that requester wins, regardless of priority.
  - Both valid: the requester that did not win the last completed grant wins.
  - After reset, requester 0 has priority.
  - The priority pointer updates at every IDLE handshake.
- **EXEC**
  - alu_a/alu_b/alu_cmd are driven from the op registers. These registers change only at the IDLE handshake and are otherwise held.
  - The counter decrements each cycle. On the cycle the counter equals 0, capture alu_z into the result register and go to RESP.
- **RESP**
  - rsp_valid_<grant_id> is high and rsp_z_<grant_id> = result register, both held stable until rsp_ready_<grant_id> is high.
  - On that handshake, go to IDLE.
  - The non-granted requester's rsp_valid is 0 and its rsp_z is 0.
- Requests arriving while busy are not accepted. The requester must hold req_valid and its operands until it sees req_ready.
- The block does not interpret CMD. All 16 codes pass straight to the ALU, and results are taken as N bits with no flags.

## Timing
- **Reset values:** state=IDLE, req_ready_*=0, rsp_valid_*=0, rsp_z_*=0, alu_a=alu_b=0, alu_cmd=0, busy=0, grant_id=0, priority to requester 0.
- **Reset asserted mid-operation:** the operation is discarded and no response is produced. After reset release, accepting a request is legal on the first clock edge.
- **Latency:** request handshake at edge T. EXEC covers cycles T+1..T+LAT. The result is captured at the end of cycle T+LAT. rsp_valid is high from cycle T+LAT+1.
- **Throughput:** if rsp_ready is already high, the response handshake completes in cycle T+LAT+1. The next request can be accepted in cycle T+LAT+2, giving one operation per LAT+2 cycles.
- **Response stall:** rsp_ready held low for any number of cycles keeps rsp_valid/rsp_z frozen. During the stall, no new request is accepted and alu_* hold their values.
- **Request/response overlap:** a req_valid arriving in the same cycle as the response handshake is accepted only on the following IDLE cycle. There is no bypass.

## Test plan
- **Single request, LAT=1:** requester 0 sends A=5, B=7, CMD=0 (ADD). Expect req_ready_0 for one cycle. Expect rsp_valid_0 with rsp_z_0=12 two cycles after the handshake, with rsp_valid_1=0 throughout.
- **Simultaneous requests after reset:** both valid; r0 sends A=9, B=4, CMD=1 (SUB), and r1 sends A=3, B=6, CMD=2 (MULT). Expect r0 served first with result 5, then r1 with 18. r1's req_valid is held high the whole time and is accepted only in the IDLE cycle after r0's response.
- **Round-robin fairness:** both requesters valid continuously for 6 operations. Expect grant order 0,1,0,1,0,1.
- **Response backpressure:** LAT=3; r1 sends A=0xFFFFFFFF, CMD=13 (INC) with rsp_ready_1 held low for 5 cycles. Expect rsp_z_1=0 held stable, alu_* unchanged, and a concurrent r0 request not accepted until after the r1 handshake.
- **Reset mid-EXEC:** LAT=4; assert rst_n low during cycle 2 of EXEC. Expect all outputs at reset values immediately. Expect no rsp_valid after release, and a fresh request accepted normally.
- **LAT=15 boundary:** a single request produces rsp_valid exactly 16 cycles after the handshake. The captured result equals the ALU output during the final EXEC cycle.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer that lends one external
// combinational ALU to two requesters. Each operation is accepted over a
// request handshake, held on the ALU for LAT settle cycles, captured, and
// returned to its owner over a response handshake.
module alu_share_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [N-1:0] req_a_0,
  input  logic [N-1:0] req_a_1,
  input  logic [N-1:0] req_b_0,
  input  logic [N-1:0] req_b_1,
  input  logic [3:0]   req_cmd_0,
  input  logic [3:0]   req_cmd_1,
  output logic         rsp_valid_0,
  output logic         rsp_valid_1,
  input  logic         rsp_ready_0,
  input  logic         rsp_ready_1,
  output logic [N-1:0] rsp_z_0,
  output logic [N-1:0] rsp_z_1,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_cmd,
  input  logic [N-1:0] alu_z,
  output logic         busy,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_prio;
  logic         r_grant;
  logic [3:0]   r_cnt;
  logic [N-1:0] r_op_a;
  logic [N-1:0] r_op_b;
  logic [3:0]   r_op_cmd;
  logic [N-1:0] r_result;

  logic         w_winner;
  logic         w_accept;
  logic         w_capture;
  logic         w_rsp_done;

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    w_winner = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      w_winner = r_prio;
    end else if (req_valid_1) begin
      w_winner = 1'b1;
    end
  end

  // Next-state logic and handshake strobes; all outputs default first.
  always_comb begin
    w_next_state = r_state;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_done   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_0 = req_valid_0 && !w_winner;
        req_ready_1 = req_valid_1 && w_winner;
        if (req_valid_0 || req_valid_1) begin
          w_accept     = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_rsp_done = r_grant ? rsp_ready_1 : rsp_ready_0;
        if (w_rsp_done) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operation registers, grant and priority pointer update only at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cmd <= 4'd0;
      r_grant  <= 1'b0;
      r_prio   <= 1'b0;
    end else if (w_accept) begin
      r_op_a   <= w_winner ? req_a_1   : req_a_0;
      r_op_b   <= w_winner ? req_b_1   : req_b_0;
      r_op_cmd <= w_winner ? req_cmd_1 : req_cmd_0;
      r_grant  <= w_winner;
      r_prio   <= ~w_winner;
    end
  end

  // Settle counter: loaded at acceptance, counts down while executing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= LAT_LOAD;
    end else if (r_state == EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Result register samples the ALU on the last settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_capture) begin
      r_result <= alu_z;
    end
  end

  assign alu_a       = r_op_a;
  assign alu_b       = r_op_b;
  assign alu_cmd     = r_op_cmd;
  assign busy        = (r_state != IDLE);
  assign grant_id    = r_grant;
  assign rsp_valid_0 = (r_state == RESP) && !r_grant;
  assign rsp_valid_1 = (r_state == RESP) && r_grant;
  assign rsp_z_0     = rsp_valid_0 ? r_result : '0;
  assign rsp_z_1     = rsp_valid_1 ? r_result : '0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: four instances at LAT 1, 3, 4 and 15,
// each wired to a behavioural model of the shared 16-function ALU.
module tb_alu_share_arbiter;

  localparam int NI = 4;

  logic        clk;
  logic        rstN;
  logic        reqValid0 [NI];
  logic        reqValid1 [NI];
  logic        reqReady0 [NI];
  logic        reqReady1 [NI];
  logic [31:0] reqA0     [NI];
  logic [31:0] reqA1     [NI];
  logic [31:0] reqB0     [NI];
  logic [31:0] reqB1     [NI];
  logic [3:0]  reqCmd0   [NI];
  logic [3:0]  reqCmd1   [NI];
  logic        rspValid0 [NI];
  logic        rspValid1 [NI];
  logic        rspReady0 [NI];
  logic        rspReady1 [NI];
  logic [31:0] rspZ0     [NI];
  logic [31:0] rspZ1     [NI];
  logic [31:0] aluA      [NI];
  logic [31:0] aluB      [NI];
  logic [3:0]  aluCmd    [NI];
  logic [31:0] aluZ      [NI];
  logic        busy      [NI];
  logic        grantId   [NI];

  int testsRun;
  int failCount;

  // Behavioural stand-in for the team ALU.
  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] cmd);
    case (cmd)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd13:   return a + 32'd1;
      4'd14:   return a - 32'd1;
      default: return a;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : genDut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;
    alu_share_arbiter #(.N(32), .LAT(L)) dut (
      .clk         (clk),
      .rst_n       (rstN),
      .req_valid_0 (reqValid0[g]),
      .req_valid_1 (reqValid1[g]),
      .req_ready_0 (reqReady0[g]),
      .req_ready_1 (reqReady1[g]),
      .req_a_0     (reqA0[g]),
      .req_a_1     (reqA1[g]),
      .req_b_0     (reqB0[g]),
      .req_b_1     (reqB1[g]),
      .req_cmd_0   (reqCmd0[g]),
      .req_cmd_1   (reqCmd1[g]),
      .rsp_valid_0 (rspValid0[g]),
      .rsp_valid_1 (rspValid1[g]),
      .rsp_ready_0 (rspReady0[g]),
      .rsp_ready_1 (rspReady1[g]),
      .rsp_z_0     (rspZ0[g]),
      .rsp_z_1     (rspZ1[g]),
      .alu_a       (aluA[g]),
      .alu_b       (aluB[g]),
      .alu_cmd     (aluCmd[g]),
      .alu_z       (aluZ[g]),
      .busy        (busy[g]),
      .grant_id    (grantId[g])
    );
    assign aluZ[g] = aluModel(aluA[g], aluB[g], aluCmd[g]);
  end

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one requester's request lines on one instance.
  task automatic applyStimulus(input int inst, input int req, input logic valid,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] cmd);
    if (req == 0) begin
      reqValid0[inst] = valid;
      reqA0[inst]     = a;
      reqB0[inst]     = b;
      reqCmd0[inst]   = cmd;
    end else begin
      reqValid1[inst] = valid;
      reqA1[inst]     = a;
      reqB1[inst]     = b;
      reqCmd1[inst]   = cmd;
    end
  endtask

  // Advances to the next falling edge plus a settle delay for sampling.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  int  who;
  bit  got;

  // Directed scenario sequence.
  initial begin
    testsRun  = 0;
    failCount = 0;
    rstN      = 1'b0;
    for (int i = 0; i < NI; i++) begin
      applyStimulus(i, 0, 1'b0, 32'd0, 32'd0, 4'd0);
      applyStimulus(i, 1, 1'b0, 32'd0, 32'd0, 4'd0);
      rspReady0[i] = 1'b0;
      rspReady1[i] = 1'b0;
    end

    // Reset values.
    nextCycle();
    nextCycle();
    checkOutput("rstBusy",     32'(busy[0]),      32'd0);
    checkOutput("rstGrant",    32'(grantId[0]),   32'd0);
    checkOutput("rstRspValid", 32'({rspValid1[0], rspValid0[0]}), 32'd0);
    checkOutput("rstRspZ0",    rspZ0[0],          32'd0);
    checkOutput("rstAluA",     aluA[0],           32'd0);
    checkOutput("rstAluCmd",   32'(aluCmd[0]),    32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Single request, LAT=1: 5+7.
    applyStimulus(0, 0, 1'b1, 32'd5, 32'd7, 4'd0);
    #1;
    checkOutput("t1Ready0",   32'(reqReady0[0]), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("t1ReadyOnce", 32'(reqReady0[0]), 32'd0);
    checkOutput("t1Busy",      32'(busy[0]),      32'd1);
    checkOutput("t1AluA",      aluA[0],           32'd5);
    checkOutput("t1RspEarly",  32'(rspValid0[0]), 32'd0);
    nextCycle();
    checkOutput("t1RspValid0", 32'(rspValid0[0]), 32'd1);
    checkOutput("t1RspZ0",     rspZ0[0],          32'd12);
    checkOutput("t1RspValid1", 32'(rspValid1[0]), 32'd0);
    rspReady0[0] = 1'b1;
    nextCycle();
    checkOutput("t1Idle",      32'(busy[0]),      32'd0);
    checkOutput("t1RspDone",   32'(rspValid0[0]), 32'd0);
    rspReady0[0] = 1'b0;

    // Reset pulse restores priority to requester 0.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    // Simultaneous requests: 9-4 then 3*6.
    applyStimulus(0, 0, 1'b1, 32'd9, 32'd4, 4'd1);
    applyStimulus(0, 1, 1'b1, 32'd3, 32'd6, 4'd2);
    rspReady0[0] = 1'b1;
    rspReady1[0] = 1'b1;
    #1;
    checkOutput("t2Ready0",    32'(reqReady0[0]), 32'd1);
    checkOutput("t2Ready1",    32'(reqReady1[0]), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("t2Ready1Exec", 32'(reqReady1[0]), 32'd0);
    nextCycle();
    checkOutput("t2Rsp0Valid", 32'(rspValid0[0]), 32'd1);
    checkOutput("t2Rsp0Z",     rspZ0[0],          32'd5);
    checkOutput("t2Ready1Rsp", 32'(reqReady1[0]), 32'd0);
    nextCycle();
    checkOutput("t2Ready1Idle", 32'(reqReady1[0]), 32'd1);
    nextCycle();
    applyStimulus(0, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("t2Grant1",    32'(grantId[0]),   32'd1);
    nextCycle();
    checkOutput("t2Rsp1Valid", 32'(rspValid1[0]), 32'd1);
    checkOutput("t2Rsp1Z",     rspZ1[0],          32'd18);
    checkOutput("t2Rsp0Off",   32'(rspValid0[0]), 32'd0);
    checkOutput("t2Rsp0ZZero", rspZ0[0],          32'd0);

    // Round-robin: both requesters held valid for six operations.
    applyStimulus(0, 0, 1'b1, 32'd10, 32'd3, 4'd0);
    applyStimulus(0, 1, 1'b1, 32'd10, 32'd3, 4'd1);
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      who = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        nextCycle();
        if (reqReady0[0]) begin
          got = 1'b1;
          who = 0;
        end else if (reqReady1[0]) begin
          got = 1'b1;
          who = 1;
        end
      end
      checkOutput($sformatf("rrAccept%0d", k), 32'(got), 32'd1);
      checkOutput($sformatf("rrGrant%0d", k), 32'(who), 32'(k % 2));
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        nextCycle();
        got = rspValid0[0] | rspValid1[0];
      end
      checkOutput($sformatf("rrRsp%0d", k), 32'(got), 32'd1);
      checkOutput($sformatf("rrRspId%0d", k), 32'(rspValid1[0]), 32'(k % 2));
      checkOutput($sformatf("rrRspZ%0d", k), grantId[0] ? rspZ1[0] : rspZ0[0],
                  (k % 2 == 1) ? 32'd7 : 32'd13);
    end
    applyStimulus(0, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    applyStimulus(0, 1, 1'b0, 32'd0, 32'd0, 4'd0);

    // Backpressure on LAT=3: INC of all-ones with rsp_ready_1 low for 5 cycles.
    applyStimulus(1, 1, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'd13);
    #1;
    checkOutput("t4Ready1", 32'(reqReady1[1]), 32'd1);
    nextCycle();
    applyStimulus(1, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    applyStimulus(1, 0, 1'b1, 32'd1, 32'd2, 4'd0);
    rspReady0[1] = 1'b1;
    #1;
    checkOutput("t4Ready0Exec1", 32'(reqReady0[1]), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      nextCycle();
      checkOutput($sformatf("t4Ready0Exec%0d", c), 32'(reqReady0[1]), 32'd0);
      checkOutput($sformatf("t4RspEarly%0d", c), 32'(rspValid1[1]), 32'd0);
    end
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      checkOutput($sformatf("t4StallValid%0d", c), 32'(rspValid1[1]), 32'd1);
      checkOutput($sformatf("t4StallZ%0d", c),     rspZ1[1],           32'd0);
      checkOutput($sformatf("t4StallAluA%0d", c),  aluA[1],            32'hFFFF_FFFF);
      checkOutput($sformatf("t4StallCmd%0d", c),   32'(aluCmd[1]),     32'd13);
      checkOutput($sformatf("t4StallReady0%0d", c), 32'(reqReady0[1]), 32'd0);
    end
    rspReady1[1] = 1'b1;
    nextCycle();
    checkOutput("t4Ready0After", 32'(reqReady0[1]), 32'd1);
    checkOutput("t4Rsp1Done",    32'(rspValid1[1]), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    rspReady1[1] = 1'b0;
    repeat (3) nextCycle();
    checkOutput("t4Rsp0Valid", 32'(rspValid0[1]), 32'd1);
    checkOutput("t4Rsp0Z",     rspZ0[1],          32'd3);
    nextCycle();
    rspReady0[1] = 1'b0;

    // Reset during EXEC cycle 2 on LAT=4.
    applyStimulus(2, 0, 1'b1, 32'd20, 32'd22, 4'd0);
    rspReady0[2] = 1'b0;
    nextCycle();
    applyStimulus(2, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    checkOutput("t5BusyExec", 32'(busy[2]), 32'd1);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t5RstBusy",  32'(busy[2]),    32'd0);
    checkOutput("t5RstAluA",  aluA[2],         32'd0);
    checkOutput("t5RstAluB",  aluB[2],         32'd0);
    checkOutput("t5RstGrant", 32'(grantId[2]), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(2, 1, 1'b1, 32'd6, 32'd7, 4'd2);
    rspReady1[2] = 1'b1;
    #1;
    checkOutput("t5FirstEdgeReady", 32'(reqReady1[2]), 32'd1);
    nextCycle();
    applyStimulus(2, 1, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) nextCycle();
      checkOutput($sformatf("t5NoRsp0_%0d", c), 32'(rspValid0[2]), 32'd0);
      checkOutput($sformatf("t5Rsp1_%0d", c), 32'(rspValid1[2]), (c == 5) ? 32'd1 : 32'd0);
    end
    checkOutput("t5Rsp1Z", rspZ1[2], 32'd42);
    nextCycle();
    rspReady1[2] = 1'b0;

    // LAT=15 boundary: 100-23, response exactly 16 cycles after handshake.
    applyStimulus(3, 0, 1'b1, 32'd100, 32'd23, 4'd1);
    rspReady0[3] = 1'b0;
    #1;
    checkOutput("t6Ready0", 32'(reqReady0[3]), 32'd1);
    nextCycle();
    applyStimulus(3, 0, 1'b1, 32'd1, 32'd1, 4'd5);
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) nextCycle();
      checkOutput($sformatf("t6Valid%0d", n), 32'(rspValid0[3]), (n == 16) ? 32'd1 : 32'd0);
      if (n == 15) checkOutput("t6AluZFinal", aluZ[3], 32'd77);
    end
    checkOutput("t6RspZ", rspZ0[3], 32'd77);
    applyStimulus(3, 0, 1'b0, 32'd0, 32'd0, 4'd0);
    rspReady0[3] = 1'b1;
    nextCycle();
    checkOutput("t6Done", 32'(busy[3]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
